// File: rtl/mod_accel_pkg.sv
// -----------------------------------------------------------------------------
// mod_accel_pkg
// Shared types and width helpers for the sequential modular-arithmetic engine.
//   op_t    : operation encoding presented on the op port
//   state_t : sequencer states of mod_accel_seq
//   dp_width / cnt_width : datapath and counter widths derived from DATA_WIDTH
// Optional feature macro: MOD_ACCEL_EXP_EN (exponentiation, see mod_accel_seq).
// -----------------------------------------------------------------------------
package mod_accel_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_RED = 3'b010,
        OP_MUL = 3'b100,
        OP_EXP = 3'b101
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALU,
        S_RED,
        S_MUL,
        S_EXP_SQ,
        S_EXP_MUL,
        S_DONE
    } state_t;

    // One guard bit above the operand width holds any value up to 2m-1.
    function automatic int dp_width(input int w);
        return w + 1;
    endfunction

    // Bits needed to count down from n to 1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// -----------------------------------------------------------------------------
// mod_mul_serial
// Interleaved shift-add modular multiplier, one multiplier bit per cycle,
// MSB first: p = 2p mod m; if bit then p = p + mcand mod m. Takes DATA_WIDTH
// steps after a load. Operands must be below m for a correct product.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture mcand_i/mplier_i, clear the product (wins over step)
//   step_i       : advance one bit while a product is in progress
//   mcand_i      : multiplicand
//   mplier_i     : multiplier, consumed MSB first
//   m_i          : modulus, held stable by the caller for the whole product
//   last_o       : the step taken this cycle is the final one
//   prod_o       : product after this cycle's step (valid with last_o)
// Optional feature macro: MOD_ACCEL_EXP_EN (no effect inside this block).
// -----------------------------------------------------------------------------
module mod_mul_serial
    import mod_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] mcand_i,
    input  logic [DATA_WIDTH-1:0] mplier_i,
    input  logic [DATA_WIDTH-1:0] m_i,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] prod_o
);
    localparam int W   = DATA_WIDTH;
    localparam int DPW = dp_width(W);
    localparam int CW  = cnt_width(W);

    logic [W-1:0]   p_q, mcand_q, mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy;
    logic [DPW-1:0] dbl_d, sum_d;
    logic [W-1:0]   dbl_red_d, sum_red_d, p_d;

    assign busy = (cnt_q != '0);

    // The guard bit only feeds the compare; the subtraction is done in W bits,
    // where wrap-around yields the exact reduced value.
    always_comb begin
        dbl_d     = {p_q, 1'b0};
        dbl_red_d = dbl_d[W-1:0] - ((dbl_d >= {1'b0, m_i}) ? m_i : '0);
        sum_d     = {1'b0, dbl_red_d} + {1'b0, mcand_q};
        sum_red_d = sum_d[W-1:0] - ((sum_d >= {1'b0, m_i}) ? m_i : '0);
        p_d       = mplier_q[W-1] ? sum_red_d : dbl_red_d;
    end

    // NOTE: only the step counter is reset; product and operand registers are
    // always reloaded before use, so resetting them would buy nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            p_q      <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            cnt_q    <= CW'(W);
        end else if (step_i && busy) begin
            p_q      <= p_d;
            mplier_q <= {mplier_q[W-2:0], 1'b0};
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    assign last_o = step_i && (cnt_q == CW'(1));
    assign prod_o = p_d;

endmodule

// File: rtl/mod_accel_seq.sv
// -----------------------------------------------------------------------------
// mod_accel_seq
// Sequential modular-arithmetic engine: add, sub, 2W-bit reduce, multiply and
// (optionally) exponentiate modulo a non-zero modulus, odd or even.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted only while ready=1
//   op         : 000 add, 001 sub, 010 reduce, 100 mult, 101 exp, others reserved
//   a, b       : operands (reduce: a high word, b low word; exp: b exponent)
//   modulant   : modulus m
//   ready      : idle, start is accepted this cycle
//   done       : one-cycle pulse, result/error valid
//   result     : registered result, held until the next result is written
//   error      : illegal request (m==0 or reserved op), held with result
// Optional feature macro: MOD_ACCEL_EXP_EN. When undefined the exponent states
// are not built and op 101 reports an error like any reserved encoding.
// -----------------------------------------------------------------------------
module mod_accel_seq
    import mod_accel_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  error
);
    localparam int W   = DATA_WIDTH;
    localparam int DPW = dp_width(W);
    localparam int CW  = cnt_width(2 * W);

    state_t         state_q;
    op_t            op_q;
    logic           ready_q, done_q, error_q;
    logic [W-1:0]   result_q, a_q, b_q, m_q, r_q;
    logic [CW-1:0]  cnt_q;

    logic           accept_d, bad_req_d, exp_more_d;
    logic [DPW-1:0] add_sum_d, red_rr_d;
    logic [W-1:0]   add_d, sub_d, red_d;
    logic           mul_load_d, mul_step_d, mul_last;
    logic [W-1:0]   mul_mcand_d, mul_mplier_d, mul_prod;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        accept_d   = ready_q && start;
        exp_more_d = 1'b0;

        case (op)
            OP_ADD, OP_SUB, OP_RED, OP_MUL: bad_req_d = 1'b0;
`ifdef MOD_ACCEL_EXP_EN
            OP_EXP:                         bad_req_d = 1'b0;
`endif
            default:                        bad_req_d = 1'b1;
        endcase
        if (modulant == '0) bad_req_d = 1'b1;

        add_sum_d = {1'b0, a_q} + {1'b0, b_q};
        add_d     = add_sum_d[W-1:0] - ((add_sum_d >= {1'b0, m_q}) ? m_q : '0);
        sub_d     = a_q - b_q + ((a_q < b_q) ? m_q : '0);

        // Restoring reduction: {a_q,b_q} is shifted out MSB first.
        red_rr_d = {r_q, a_q[W-1]};
        red_d    = red_rr_d[W-1:0] - ((red_rr_d >= {1'b0, m_q}) ? m_q : '0);

        mul_load_d   = 1'b0;
        mul_mcand_d  = a;
        mul_mplier_d = b;
        mul_step_d   = (state_q == S_MUL) || (state_q == S_EXP_SQ) || (state_q == S_EXP_MUL);

        // The multiplier is loaded on the accept edge straight from the ports,
        // so the first step lands in cycle 1.
        if (state_q == S_IDLE && accept_d && !bad_req_d) begin
            if (op == OP_MUL) begin
                mul_load_d = 1'b1;
            end
`ifdef MOD_ACCEL_EXP_EN
            else if (op == OP_EXP) begin
                mul_load_d   = 1'b1;
                mul_mcand_d  = (modulant == W'(1)) ? '0 : W'(1);
                mul_mplier_d = (modulant == W'(1)) ? '0 : W'(1);
            end
`endif
        end

`ifdef MOD_ACCEL_EXP_EN
        // Chain the next product on the same edge the current one finishes,
        // so exponent phases run back to back with no idle cycle.
        exp_more_d = (cnt_q != CW'(1));
        if (mul_last) begin
            if (state_q == S_EXP_SQ && b_q[W-1]) begin
                mul_load_d   = 1'b1;
                mul_mcand_d  = a_q;
                mul_mplier_d = mul_prod;
            end else if ((state_q == S_EXP_SQ || state_q == S_EXP_MUL) && exp_more_d) begin
                mul_load_d   = 1'b1;
                mul_mcand_d  = mul_prod;
                mul_mplier_d = mul_prod;
            end
        end
`endif
    end

    mod_mul_serial #(.DATA_WIDTH(W)) u_mul (
        .clk      (clk),
        .reset    (reset),
        .load_i   (mul_load_d),
        .step_i   (mul_step_d),
        .mcand_i  (mul_mcand_d),
        .mplier_i (mul_mplier_d),
        .m_i      (m_q),
        .last_o   (mul_last),
        .prod_o   (mul_prod)
    );

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        a_q     <= a;
                        b_q     <= b;
                        m_q     <= modulant;
                        op_q    <= (op == OP_SUB) ? OP_SUB : OP_ADD;
                        r_q     <= '0;
                        ready_q <= 1'b0;
                        error_q <= 1'b0;
                        if (bad_req_d) begin
                            result_q <= '0;
                            error_q  <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            case (op)
                                OP_ADD, OP_SUB: state_q <= S_ALU;
                                OP_RED: begin
                                    cnt_q   <= CW'(2 * W);
                                    state_q <= S_RED;
                                end
                                OP_MUL: state_q <= S_MUL;
`ifdef MOD_ACCEL_EXP_EN
                                OP_EXP: begin
                                    cnt_q   <= CW'(W);
                                    state_q <= S_EXP_SQ;
                                end
`endif
                                default: state_q <= S_DONE;
                            endcase
                        end
                    end
                end
                S_ALU: begin
                    result_q <= (op_q == OP_SUB) ? sub_d : add_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_RED: begin
                    r_q        <= red_d;
                    {a_q, b_q} <= {a_q[W-2:0], b_q, 1'b0};
                    cnt_q      <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        result_q <= red_d;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        result_q <= mul_prod;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`ifdef MOD_ACCEL_EXP_EN
                // b_q[W-1] is the exponent bit being processed; it is shifted
                // away once both its square and optional multiply are done.
                S_EXP_SQ: begin
                    if (mul_last) begin
                        if (b_q[W-1]) begin
                            state_q <= S_EXP_MUL;
                        end else if (exp_more_d) begin
                            b_q   <= {b_q[W-2:0], 1'b0};
                            cnt_q <= cnt_q - CW'(1);
                        end else begin
                            result_q <= mul_prod;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_EXP_MUL: begin
                    if (mul_last) begin
                        if (exp_more_d) begin
                            b_q     <= {b_q[W-2:0], 1'b0};
                            cnt_q   <= cnt_q - CW'(1);
                            state_q <= S_EXP_SQ;
                        end else begin
                            result_q <= mul_prod;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_mod_accel_seq.sv
// -----------------------------------------------------------------------------
// tb_mod_accel_seq
// Directed vectors with hand-computed results for mod_accel_seq (W=8).
// Stimulus pushes the expected result, error flag and done cycle into a
// scoreboard queue; an independent monitor pops and compares on every done.
// Expected values for op 101 follow MOD_ACCEL_EXP_EN.
// -----------------------------------------------------------------------------
module tb_mod_accel_seq;

    localparam int W = 8;
`ifdef MOD_ACCEL_EXP_EN
    localparam bit EXP_EN = 1'b1;
`else
    localparam bit EXP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0, b = '0, modulant = '0;
    logic         ready, done, error;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int    res;
        int    err;
        int    due;
        string name;
    } exp_t;

    exp_t sb[$];

    mod_accel_seq #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .modulant (modulant),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .error    (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every done must match the oldest expectation, and the engine
    // must be ready again in the following cycle.
    initial begin
        bit prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (prev_done) check("ready_after_done", int'(ready), 1);
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", int'(done), 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check({e.name, "_result"}, int'(result), e.res);
                        check({e.name, "_error"}, int'(error), e.err);
                        check({e.name, "_done_cycle"}, cyc, e.due);
                    end
                end
                prev_done = done;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    // Issue one request and wait for the scoreboard to drain. With noise set,
    // start is pulsed with junk operands during cycles 3..10 after accept.
    task automatic run_op(input logic [2:0] o, input int ia, input int ib, input int im,
                          input int er, input int ee, input int lat,
                          input string nm, input bit noise);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (!ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ready) begin
            check({nm, "_ready_wait"}, int'(ready), 1);
            return;
        end
        op = o; a = W'(ia); b = W'(ib); modulant = W'(im); start = 1'b1;
        e.res = er; e.err = ee; e.due = cyc + lat; e.name = nm;
        sb.push_back(e);
        for (int k = 1; k <= 2000 && sb.size() != 0; k++) begin
            @(negedge clk);
            if (noise && k >= 3 && k <= 10) begin
                start = 1'b1; op = 3'b000; a = W'(k); b = W'(255 - k); modulant = 8'd7;
                check({nm, "_busy_ready"}, int'(ready), 0);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (sb.size() != 0) begin
            check({nm, "_timeout"}, sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        int acc;
        int n_rst;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_result", int'(result), 0);
        check("reset_error", int'(error), 0);

        // add / sub
        run_op(3'b000, 7, 9, 13, 3, 0, 2, "add_7_9", 1'b0);
        run_op(3'b001, 3, 5, 13, 11, 0, 2, "sub_3_5", 1'b0);
        run_op(3'b000, 12, 12, 13, 11, 0, 2, "add_12_12", 1'b0);
        run_op(3'b000, 254, 254, 255, 253, 0, 2, "add_254_254_m255", 1'b0);
        run_op(3'b001, 5, 5, 13, 0, 0, 2, "sub_5_5", 1'b0);
        run_op(3'b001, 0, 12, 13, 1, 0, 2, "sub_0_12", 1'b0);

        // reduce
        run_op(3'b010, 8'h01, 8'h00, 13, 9, 0, 17, "red_256", 1'b1);
        run_op(3'b010, 8'hFF, 8'hFF, 13, 2, 0, 17, "red_65535", 1'b0);

        // mult
        run_op(3'b100, 7, 9, 13, 11, 0, 9, "mul_7_9_m13", 1'b0);
        run_op(3'b100, 7, 9, 12, 3, 0, 9, "mul_7_9_m12", 1'b0);
        run_op(3'b100, 12, 12, 13, 1, 0, 9, "mul_12_12", 1'b0);
        run_op(3'b100, 254, 254, 255, 1, 0, 9, "mul_254_254_m255", 1'b0);

        // exp (reserved when the feature is not built)
        run_op(3'b101, 2, 10, 13, EXP_EN ? 10 : 0, EXP_EN ? 0 : 1, EXP_EN ? 81 : 1, "exp_2_10", 1'b0);
        run_op(3'b101, 5, 0, 13, EXP_EN ? 1 : 0, EXP_EN ? 0 : 1, EXP_EN ? 65 : 1, "exp_5_0", 1'b0);
        run_op(3'b101, 0, 3, 1, 0, EXP_EN ? 0 : 1, EXP_EN ? 81 : 1, "exp_m1", 1'b0);
        run_op(3'b101, 3, 255, 13, EXP_EN ? 1 : 0, EXP_EN ? 0 : 1, EXP_EN ? 129 : 1, "exp_3_255", 1'b0);
        run_op(3'b101, 7, 9, 12, EXP_EN ? 7 : 0, EXP_EN ? 0 : 1, EXP_EN ? 81 : 1, "exp_7_9_m12", 1'b0);

        // errors, then a valid add clears the flag
        run_op(3'b000, 1, 2, 0, 0, 1, 1, "err_m0", 1'b0);
        run_op(3'b011, 1, 2, 13, 0, 1, 1, "err_op011", 1'b0);
        run_op(3'b110, 1, 2, 13, 0, 1, 1, "err_op110", 1'b0);
        run_op(3'b111, 1, 2, 13, 0, 1, 1, "err_op111", 1'b0);
        run_op(3'b000, 7, 9, 13, 3, 0, 2, "add_after_err", 1'b0);

        // reset in the middle of a long operation
        n_rst = EXP_EN ? 30 : 10;
        @(negedge clk);
        op = EXP_EN ? 3'b101 : 3'b010; a = 8'd2; b = 8'd10; modulant = 8'd13; start = 1'b1;
        acc = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + n_rst) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midop_reset_ready", int'(ready), 1);
        check("midop_reset_done", int'(done), 0);
        check("midop_reset_result", int'(result), 0);
        repeat (150) @(negedge clk);

        run_op(3'b001, 12, 1, 13, 11, 0, 2, "sub_after_reset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mod_accel_seq.md
Name: mod_accel_seq

Overview:
- Sequential, parametrised modular-arithmetic engine computing add, sub, double-width reduce, multiply and exponentiate modulo `modulant`.
- Next generation of the accelerator interface, for use as the processor-side arithmetic peripheral:
  - start/ready/done handshake with operands latched at accept;
  - registered result held until the next operation;
  - works for any non-zero modulus, even or odd, with no R-constant setup step.

Parameters:
- DATA_WIDTH, 8, operand/modulus/result width W; legal range W >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when ready=1.
- op  input  3  operation: 000 add, 001 sub, 010 reduce, 100 mult, 101 exp; 011/110/111 reserved.
- a  input  W  operand A, or high word for reduce.
- b  input  W  operand B, low word for reduce, exponent for exp.
- modulant  input  W  modulus m.
- ready  output  1  engine idle; start will be accepted this cycle.
- done  output  1  one-cycle pulse; result/error valid.
- result  output  W  registered result, held until next accepted start.
- error  output  1  set with done for illegal request, held with result.

Behaviour:
- Reset (synchronous; wins over every other event, including mid-operation): state IDLE, ready=1, done=0, result=0, error=0; any in-flight operation is discarded.
- Accept: cycle where ready&&start. Latches a, b, op, m into internal registers; clears error; ready falls the next cycle. Input changes while busy have no effect.
- States and transitions:
  - IDLE -> ALU | RED | MUL | EXP_SQ | DONE(error).
  - ALU -> DONE after 1 cycle.
  - RED/MUL -> DONE after their iteration count.
  - EXP_SQ <-> EXP_MUL -> DONE.
  - DONE -> IDLE unconditionally.
  - done=1 only in DONE. start while not ready (including the DONE cycle) is ignored.
- Errors: m==0 or reserved op -> DONE next cycle, result=0, error=1.
- Precondition a<m and b<m for add/sub/mult. For exp only a<m is required; b is an arbitrary exponent. Results are unspecified, but must not hang, if a precondition is violated.
- Internal datapath W+1 bits. No intermediate value may exceed 2m-1.
- add: s=a+b (W+1 bits); result = s>=m ? s-m : s. sub: result = a>=b ? a-b : a-b+m.
- reduce: X={a,b} (2W bits), result = X mod m.
  - Bit-serial restoring: r=0; for 2W cycles MSB first: r=2r+bit; if r>=m then r-=m.
- mult: interleaved shift-add, W cycles, B bits MSB first.
  - Each cycle: p=2p mod m; if bit then p=p+a mod m; p initially 0.
- exp: left-to-right square-and-multiply over all W exponent bits, no leading-zero skip.
  - x init = (m==1) ? 0 : 1.
  - Per bit: x=x*x mod m (EXP_SQ, W cycles); if bit=1 then x=x*a mod m (EXP_MUL, W cycles).
- Latency, accept cycle = 0, done high at cycle:
  - add/sub: 1+1 = 2;
  - reduce: 2W+1;
  - mult: W+1;
  - exp: W*W + popcount(b)*W + 1;
  - error: 1.
- Back-to-back throughput: next accept is possible the cycle after done.

Optional Feature:
- MOD_ACCEL_EXP_EN: when defined, exp is implemented as above.
- When undefined, EXP_SQ/EXP_MUL are not built and op 101 is treated as reserved (error=1, done at cycle 1). Area drops accordingly.

Decomposition:
- Package mod_accel_pkg: op_t enum (OP_ADD, OP_SUB, OP_RED, OP_MUL, OP_EXP), state_t enum, localparam widths derived from DATA_WIDTH via package function.
- One natural sub-module: mod_mul_serial.
  - One-bit-per-cycle interleaved modular multiplier with load/step/busy.
  - Shared by MUL and both exp phases.
  - The top FSM owns the sequencing and the operand muxing of x/a into it.

Test Plan (W=8, m=13 unless noted):
- add a=7,b=9 -> result=3, error=0, done at cycle 2; sub a=3,b=5 -> result=11.
- reduce a=0x01,b=0x00 (256) -> result=9, done at cycle 17; start pulses at cycles 3-10 ignored, ready=0 throughout.
- mult a=7,b=9 -> result=11 at cycle 9; repeat with m=12 (even), a=7,b=9 -> result=3.
- exp a=2,b=10 -> result=10, done at cycle 81 (64+16+1); exp a=5,b=0 -> 1; exp with m=1, a=0,b=3 -> 0.
- m=0 or op=011 -> done at cycle 1, result=0, error=1; next valid add clears error.
- reset asserted at cycle 30 of exp -> next cycle ready=1, done=0, result=0; no spurious done afterwards. Without MOD_ACCEL_EXP_EN, op=101 -> error=1 at cycle 1.
